// File: rtl/spram_banked_pkg.sv
// Shared types and helpers for the banked single-port RAM.
package spram_banked_pkg;

    // Power-state encoding, visible on pwr_state
    typedef enum logic [2:0] {
        PWR_OFF    = 3'd0,
        PWR_CLEAR  = 3'd1,
        PWR_ACTIVE = 3'd2,
        PWR_DRAIN  = 3'd3,
        PWR_STDBY  = 3'd4,
        PWR_SLEEP  = 3'd5,
        PWR_WAKE   = 3'd6
    } pwr_e;

    localparam int NIB_W = 4;

    // Expand a per-nibble mask (up to 16 nibbles) to a per-bit mask
    function automatic logic [63:0] nib_expand(input logic [15:0] m);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            e[i*NIB_W +: NIB_W] = {NIB_W{m[i]}};
        end
        return e;
    endfunction

endpackage

// File: rtl/spram_banked_if.sv
// Request/response bus of the banked RAM: valid/ready request, fixed-latency read response.
interface spram_banked_if #(
    parameter int DW    = 16,
    parameter int AW    = 14,
    parameter int NBANK = 4
) ();
    localparam int ABW = AW + $clog2(NBANK);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ABW-1:0]    req_addr;
    logic [DW/4-1:0]   req_mask;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_mask, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_mask, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spram_banked_bank.sv
// One AW x DW single-port bank: chip select, write enable, nibble write mask, registered read.
module spram_banked_bank
    import spram_banked_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 14
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW/4-1:0]   mask,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] bmask;

    assign bmask = DW'(nib_expand(16'(mask)));

    // Masked write or registered read; read data holds while the bank is idle
    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/spram_banked.sv
// Banked single-port RAM with power-state FSM, scrub-on-power-up and fixed read latency.
module spram_banked
    import spram_banked_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 14,
    parameter int NBANK    = 4,
    parameter int RD_LAT   = 1,
    parameter int WAKE_CYC = 4,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    spram_banked_if.slave     bus,
    input  logic              stdby,
    input  logic              sleep,
    input  logic              pwroff_n,
    output logic [2:0]        pwr_state
);
    localparam int BW  = $clog2(NBANK);
    localparam int MW  = DW / NIB_W;
    localparam int WCW = $clog2(WAKE_CYC + 1);

    pwr_e             state;
    pwr_e             tgt;
    logic             ready_r;
    logic [AW-1:0]    clr_cnt;
    logic [WCW-1:0]   wake_cnt;
    logic             drained;

    logic             acc;
    logic             rd_acc;
    logic [BW-1:0]    bsel;
    logic [NBANK-1:0] cs;
    logic             we_b;
    logic [AW-1:0]    addr_b;
    logic [MW-1:0]    mask_b;
    logic [DW-1:0]    wdata_b;
    logic [DW-1:0]    bank_q [NBANK];

    logic             vld_p0;
    logic             vld_p1;
    logic [BW-1:0]    sel_p0;
    logic [DW-1:0]    rdata_p1;
    logic             rd_seen;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             zero_out;

    // With one-cycle latency the only possible in-flight read is being delivered right now
    assign drained = (RD_LAT == 2) ? !vld_p0 : 1'b1;

    // Power-state FSM; req_ready is registered and high exactly while in ACTIVE
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b0;
            clr_cnt  <= '0;
            wake_cnt <= '0;
            tgt      <= PWR_STDBY;
            if (!pwroff_n)          state <= PWR_OFF;
            else if (CLEAR_EN != 0) state <= PWR_CLEAR;
            else                    state <= PWR_ACTIVE;
        end else begin
            case (state)
                PWR_OFF: begin
                    ready_r <= 1'b0;
                    if (pwroff_n) begin
                        clr_cnt <= '0;
                        if (CLEAR_EN != 0) begin
                            state <= PWR_CLEAR;
                        end else begin
                            state   <= PWR_ACTIVE;
                            ready_r <= 1'b1;
                        end
                    end
                end
                PWR_CLEAR: begin
                    if (!pwroff_n) begin
                        state <= PWR_OFF;
                    end else if (&clr_cnt) begin
                        state   <= PWR_ACTIVE;
                        ready_r <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                PWR_ACTIVE: begin
                    if (!pwroff_n || sleep || stdby) begin
                        state   <= PWR_DRAIN;
                        ready_r <= 1'b0;
                        if (!pwroff_n)  tgt <= PWR_OFF;
                        else if (sleep) tgt <= PWR_SLEEP;
                        else            tgt <= PWR_STDBY;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                PWR_DRAIN: begin
                    // The request that caused the drain is remembered, so a one-cycle pulse still lands
                    if (drained) begin
                        if (!pwroff_n || tgt == PWR_OFF)      state <= PWR_OFF;
                        else if (sleep || tgt == PWR_SLEEP)   state <= PWR_SLEEP;
                        else                                  state <= PWR_STDBY;
                    end else if (pwroff_n && !sleep && !stdby) begin
                        state   <= PWR_ACTIVE;
                        ready_r <= 1'b1;
                    end else if (!pwroff_n) begin
                        tgt <= PWR_OFF;
                    end else if (sleep && tgt != PWR_OFF) begin
                        tgt <= PWR_SLEEP;
                    end
                end
                PWR_STDBY: begin
                    if (!pwroff_n) begin
                        state <= PWR_OFF;
                    end else if (sleep) begin
                        state <= PWR_SLEEP;
                    end else if (!stdby) begin
                        state   <= PWR_ACTIVE;
                        ready_r <= 1'b1;
                    end
                end
                PWR_SLEEP: begin
                    if (!pwroff_n) begin
                        state <= PWR_OFF;
                    end else if (!sleep) begin
                        state    <= PWR_WAKE;
                        wake_cnt <= '0;
                    end
                end
                PWR_WAKE: begin
                    if (!pwroff_n) begin
                        state <= PWR_OFF;
                    end else if (sleep) begin
                        state <= PWR_SLEEP;
                    end else if (wake_cnt == WCW'(WAKE_CYC - 1)) begin
                        state   <= PWR_ACTIVE;
                        ready_r <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= PWR_OFF;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Bank decode: scrub drives every bank at once, otherwise only the addressed bank is selected
    always_comb begin
        acc     = bus.req_valid && ready_r;
        rd_acc  = acc && !bus.req_we;
        bsel    = bus.req_addr[AW +: BW];
        cs      = '0;
        we_b    = bus.req_we;
        addr_b  = bus.req_addr[AW-1:0];
        mask_b  = bus.req_mask;
        wdata_b = bus.req_wdata;
        if (state == PWR_CLEAR) begin
            cs      = '1;
            we_b    = 1'b1;
            addr_b  = clr_cnt;
            mask_b  = '1;
            wdata_b = '0;
        end else if (acc) begin
            cs[bsel] = 1'b1;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        spram_banked_bank #(.DW(DW), .AW(AW)) u_bank (
            .clk   (clk),
            .cs    (cs[b]),
            .we    (we_b),
            .addr  (addr_b),
            .mask  (mask_b),
            .wdata (wdata_b),
            .rdata (bank_q[b])
        );
    end

    // Stage p0/p1 boundary: read-valid shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            rd_seen <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            vld_p1 <= (RD_LAT == 2) && vld_p0;
            if (state == PWR_OFF)  rd_seen <= 1'b0;
            else if (rsp_valid)    rd_seen <= 1'b1;
        end
    end

    // Stage p0/p1 boundary: bank select capture and optional output register
    always_ff @(posedge clk) begin
        if (rd_acc) sel_p0   <= bsel;
        if (vld_p0) rdata_p1 <= bank_q[sel_p0];
    end

    assign rsp_valid = (RD_LAT == 2) ? vld_p1 : vld_p0;
    assign rsp_data  = (RD_LAT == 2) ? rdata_p1 : bank_q[sel_p0];
    assign zero_out  = (state == PWR_OFF) || (state == PWR_SLEEP) || (state == PWR_CLEAR)
                       || !(rd_seen || rsp_valid);

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = zero_out ? '0 : rsp_data;
    assign pwr_state     = state;
endmodule

// File: tb/tb_spram_banked.sv
// Bench for spram_banked: RD_LAT=1 full-size instance and a small RD_LAT=2 instance.
module tb_spram_banked;
    import spram_banked_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       stdby1, sleep1, pwroff1;
    logic       stdby2, sleep2, pwroff2;
    logic [2:0] st1, st2;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    spram_banked_if #(.DW(16), .AW(14), .NBANK(4)) b1 ();
    spram_banked_if #(.DW(16), .AW(6),  .NBANK(4)) b2 ();

    spram_banked #(.DW(16), .AW(14), .NBANK(4), .RD_LAT(1), .WAKE_CYC(4), .CLEAR_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .stdby(stdby1), .sleep(sleep1), .pwroff_n(pwroff1), .pwr_state(st1)
    );

    spram_banked #(.DW(16), .AW(6), .NBANK(4), .RD_LAT(2), .WAKE_CYC(4), .CLEAR_EN(1)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave),
        .stdby(stdby2), .sleep(sleep2), .pwroff_n(pwroff2), .pwr_state(st2)
    );

    typedef struct { int cyc; logic [15:0] d; } exp_t;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] m1 [int];
    logic [15:0] m2 [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mread(input int d, input int a);
        if (d == 0) return m1.exists(a) ? m1[a] : 16'h0;
        return m2.exists(a) ? m2[a] : 16'h0;
    endfunction

    function automatic void mwrite(input int d, input int a, input logic [3:0] m, input logic [15:0] w);
        logic [15:0] o;
        o = mread(d, a);
        for (int i = 0; i < 4; i++) if (m[i]) o[4*i +: 4] = w[4*i +: 4];
        if (d == 0) m1[a] = o; else m2[a] = o;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? b1.req_ready : b2.req_ready;
    endfunction

    function automatic logic [2:0] cur(input int d);
        return (d == 0) ? st1 : st2;
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input int a,
                         input logic [3:0] m, input logic [15:0] w);
        if (d == 0) begin
            b1.req_valid = v; b1.req_we = we; b1.req_addr = a[15:0];
            b1.req_mask = m;  b1.req_wdata = w;
        end else begin
            b2.req_valid = v; b2.req_we = we; b2.req_addr = a[7:0];
            b2.req_mask = m;  b2.req_wdata = w;
        end
    endtask

    // One request, held until accepted; a read registers its expected response and cycle
    task automatic access(input int d, input logic we, input int a, input logic [3:0] m,
                          input logic [15:0] w, input logic [15:0] exp);
        int k;
        k = 0;
        drive(d, 1'b1, we, a, m, w);
        while (!rdy(d) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_ready", 32'(rdy(d)), 32'd1);
        if (rdy(d)) begin
            if (we)          mwrite(d, a, m, w);
            else if (d == 0) q1.push_back('{cyc + 1, exp});
            else             q2.push_back('{cyc + 2, exp});
        end
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 0, 4'h0, 16'h0);
    endtask

    task automatic count_low(input int d, output int n);
        n = 0;
        while (rdy(d) == 1'b0 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input int d, input pwr_e s, input string tag);
        int k;
        k = 0;
        while (cur(d) != s && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(cur(d)), 32'(s));
    endtask

    // Response monitors: every rsp_valid must match the oldest outstanding read, on its exact cycle
    always @(negedge clk) begin : mon1
        exp_t e;
        if (b1.rsp_valid) begin
            if (q1.size() == 0) check("rsp1_extra", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("rsp1_cycle", cyc, e.cyc);
                check("rsp1_data", 32'(b1.rsp_rdata), 32'(e.d));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (b2.rsp_valid) begin
            if (q2.size() == 0) check("rsp2_extra", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                check("rsp2_cycle", cyc, e.cyc);
                check("rsp2_data", 32'(b2.rsp_rdata), 32'(e.d));
            end
        end
    end

    initial begin
        int n;
        int a;
        logic [15:0] w;

        rst = 1'b1;
        pwroff1 = 1'b0; stdby1 = 1'b0; sleep1 = 1'b0;
        pwroff2 = 1'b1; stdby2 = 1'b0; sleep2 = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 4'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 0, 4'h0, 16'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state_off", 32'(st1), 32'(PWR_OFF));
        check("rst_ready", 32'(b1.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(b1.rsp_rdata), 32'd0);
        pwroff1 = 1'b1;
        @(negedge clk);
        check("rst_state_clear", 32'(st1), 32'(PWR_CLEAR));
        rst = 1'b0;
        count_low(0, n);
        check("clear_cycles", n, 16384);
        check("after_clear_active", 32'(st1), 32'(PWR_ACTIVE));

        // Scrubbed contents read as zero
        access(0, 1'b0, 16'h0000, 4'h0, 16'h0, 16'h0000);
        access(0, 1'b0, 16'hFFFF, 4'h0, 16'h0, 16'h0000);

        // Nibble-masked write
        access(0, 1'b1, 16'h0005, 4'hF, 16'h1234, 16'h0);
        access(0, 1'b1, 16'h0005, 4'h5, 16'hABCD, 16'h0);
        access(0, 1'b0, 16'h0005, 4'h0, 16'h0, 16'h1B3D);

        // One word per bank, then back-to-back reads across banks
        for (int i = 0; i < 4; i++) access(0, 1'b1, i << 14, 4'hF, 16'hC0DE ^ 16'(i * 16'h1111), 16'h0);
        for (int i = 0; i < 4; i++) access(0, 1'b0, i << 14, 4'h0, 16'h0, 16'hC0DE ^ 16'(i * 16'h1111));

        // Random mix against the model
        repeat (300) begin
            a = ($urandom_range(0, 3) << 14) | $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) access(0, 1'b1, a, 4'($urandom), 16'($urandom), 16'h0);
            else                           access(0, 1'b0, a, 4'h0, 16'h0, mread(0, a));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Read accepted in the same cycle sleep rises; response delivered, then SLEEP, then WAKE
        sleep1 = 1'b1;
        access(0, 1'b0, 16'h0005, 4'h0, 16'h0, mread(0, 16'h0005));
        wait_state(0, PWR_SLEEP, "enter_sleep");
        check("sleep_ready", 32'(b1.req_ready), 32'd0);
        check("sleep_rdata_zero", 32'(b1.rsp_rdata), 32'd0);
        sleep1 = 1'b0;
        @(negedge clk);
        check("wake_state", 32'(st1), 32'(PWR_WAKE));
        count_low(0, n);
        check("wake_cycles", n, 4);
        check("wake_active", 32'(st1), 32'(PWR_ACTIVE));
        access(0, 1'b0, 16'h0005, 4'h0, 16'h0, mread(0, 16'h0005));
        access(0, 1'b0, 16'hC000, 4'h0, 16'h0, mread(0, 16'hC000));
        repeat (3) @(negedge clk);

        // Power off, abort the scrub, then a full scrub from word 0
        pwroff1 = 1'b0;
        wait_state(0, PWR_OFF, "enter_off");
        pwroff1 = 1'b1;
        @(negedge clk);
        check("off_to_clear", 32'(st1), 32'(PWR_CLEAR));
        repeat (100) @(negedge clk);
        pwroff1 = 1'b0;
        @(negedge clk);
        check("clear_abort_off", 32'(st1), 32'(PWR_OFF));
        check("clear_abort_ready", 32'(b1.req_ready), 32'd0);
        check("off_rdata_zero", 32'(b1.rsp_rdata), 32'd0);
        pwroff1 = 1'b1;
        @(negedge clk);
        count_low(0, n);
        check("rescrub_cycles", n, 16384);
        m1.delete();
        access(0, 1'b0, 16'h0005, 4'h0, 16'h0, 16'h0000);
        access(0, 1'b0, 16'hC000, 4'h0, 16'h0, 16'h0000);

        // RD_LAT=2 instance: random traffic
        repeat (120) begin
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) access(1, 1'b1, a, 4'($urandom), 16'($urandom), 16'h0);
            else                           access(1, 1'b0, a, 4'h0, 16'h0, mread(1, a));
        end
        repeat (4) @(negedge clk);

        // One-cycle stdby pulse with nothing in flight
        stdby2 = 1'b1;
        @(negedge clk);
        stdby2 = 1'b0;
        check("stdby_drain", 32'(st2), 32'(PWR_DRAIN));
        @(negedge clk);
        check("stdby_state", 32'(st2), 32'(PWR_STDBY));
        @(negedge clk);
        check("stdby_active", 32'(st2), 32'(PWR_ACTIVE));
        check("stdby_ready", 32'(b2.req_ready), 32'd1);

        // Read accepted with a stdby pulse, then back-to-back reads
        stdby2 = 1'b1;
        access(1, 1'b0, 8'h11, 4'h0, 16'h0, mread(1, 8'h11));
        stdby2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = (i << 6) | 3;
            access(1, 1'b0, a, 4'h0, 16'h0, mread(1, a));
        end

        repeat (6) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
